// File: rtl/pattern_gen_64b.sv
// pattern_gen_64b: burst/gap source of a 64-bit incrementing pattern on a valid/ready link.
// Optional bit-0 error injection is compiled in when PATGEN_ERR_INJ_EN is defined.
module pattern_gen_64b #(
   parameter int GAP_LEN = 8
) (
   input  logic        clk_usr,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [15:0] burst_len,
`ifdef PATGEN_ERR_INJ_EN
   input  logic        err_inj,
`endif
   output logic [63:0] usr_tx,
   output logic        usr_tx_valid,
   input  logic        usr_tx_ready,
   output logic        busy,
   output logic [31:0] word_cnt
);

   localparam logic [63:0] PAT_INIT = 64'h0000_0002_0000_0001;
   localparam logic [63:0] PAT_INC  = 64'h0000_0002_0000_0002;
   localparam logic [7:0]  GAP_LAST = 8'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

   typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

   state_t      state_q, state_d;
   logic [63:0] pat_q, pat_d;
   logic [15:0] beat_left_q, beat_left_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        stop_req_q, stop_req_d;
   logic [31:0] word_cnt_q, word_cnt_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        accept;

   function automatic logic [15:0] reload_len(input logic [15:0] len);
      return (len == 16'd0) ? 16'd1 : len;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign accept = valid_q && usr_tx_ready;

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      beat_left_d = beat_left_q;
      gap_cnt_d   = gap_cnt_q;
      stop_req_d  = stop_req_q;
      word_cnt_d  = word_cnt_q;

      if (accept) begin
         pat_d      = pat_q + PAT_INC;
         word_cnt_d = sat_inc32(word_cnt_q);
      end

      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d     = BURST;
               beat_left_d = reload_len(burst_len);
               word_cnt_d  = 32'd0;
               stop_req_d  = 1'b0;
            end
         end
         BURST: begin
            if (stop) stop_req_d = 1'b1;
            if (accept) begin
               // A pending stop ends the run at the first accept, whatever is left of the burst.
               if (stop || stop_req_q) begin
                  state_d     = IDLE;
                  stop_req_d  = 1'b0;
                  beat_left_d = 16'd0;
               end else if (beat_left_q == 16'd1) begin
                  if (GAP_LEN == 0) begin
                     beat_left_d = reload_len(burst_len);
                  end else begin
                     state_d     = GAP;
                     beat_left_d = 16'd0;
                     gap_cnt_d   = 8'd0;
                  end
               end else begin
                  beat_left_d = beat_left_q - 16'd1;
               end
            end
         end
         GAP: begin
            if (stop) begin
               state_d   = IDLE;
               gap_cnt_d = 8'd0;
            end else if (gap_cnt_q == GAP_LAST) begin
               state_d     = BURST;
               gap_cnt_d   = 8'd0;
               beat_left_d = reload_len(burst_len);
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      valid_d = (state_d == BURST);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk_usr or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         pat_q       <= PAT_INIT;
         beat_left_q <= 16'd0;
         gap_cnt_q   <= 8'd0;
         stop_req_q  <= 1'b0;
         word_cnt_q  <= 32'd0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         beat_left_q <= beat_left_d;
         gap_cnt_q   <= gap_cnt_d;
         stop_req_q  <= stop_req_d;
         word_cnt_q  <= word_cnt_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
      end
   end

`ifdef PATGEN_ERR_INJ_EN
   logic inj_flag_q, inj_flag_d;

   // A new injection request wins over a coincident accept so it lands on the next word.
   always_comb begin
      inj_flag_d = inj_flag_q;
      if (accept)  inj_flag_d = 1'b0;
      if (err_inj) inj_flag_d = 1'b1;
   end

   always_ff @(posedge clk_usr or posedge rst) begin
      if (rst) inj_flag_q <= 1'b0;
      else     inj_flag_q <= inj_flag_d;
   end

   assign usr_tx = pat_q ^ {63'd0, inj_flag_q};
`else
   assign usr_tx = pat_q;
`endif

   assign usr_tx_valid = valid_q;
   assign busy         = busy_q;
   assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_pattern_gen_64b.sv
// Self-checking bench for pattern_gen_64b: directed scenarios plus randomized traffic
// against a scoreboard of the expected pattern sequence and burst/gap/stop rules.
module tb_pattern_gen_64b;

   localparam int          GAP_LEN  = 8;
   localparam logic [63:0] PAT_INIT = 64'h0000_0002_0000_0001;
   localparam logic [63:0] PAT_INC  = 64'h0000_0002_0000_0002;

   logic        clk_usr = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [15:0] burst_len = 16'd0;
   logic [63:0] usr_tx;
   logic        usr_tx_valid;
   logic        usr_tx_ready = 1'b0;
   logic        busy;
   logic [31:0] word_cnt;
`ifdef PATGEN_ERR_INJ_EN
   logic        err_inj = 1'b0;
`endif

   int          n_tests = 0;
   int          n_fail = 0;
   logic [63:0] exp_pat = PAT_INIT;
   logic [31:0] exp_cnt = 32'd0;
   logic        stop_pend = 1'b0;
   int          burst_beats = 0;
   int          gap_cycles = 0;
   int          bl = 4;
   logic [63:0] first_words [4];

   pattern_gen_64b #(.GAP_LEN(GAP_LEN)) dut (
      .clk_usr      (clk_usr),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .burst_len    (burst_len),
`ifdef PATGEN_ERR_INJ_EN
      .err_inj      (err_inj),
`endif
      .usr_tx       (usr_tx),
      .usr_tx_valid (usr_tx_valid),
      .usr_tx_ready (usr_tx_ready),
      .busy         (busy),
      .word_cnt     (word_cnt)
   );

   always #5 clk_usr = ~clk_usr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Called at a falling edge; applies inputs for one cycle, scores the edge, returns at the next falling edge.
   task automatic cyc(input logic st, input logic sp, input logic rdy);
      logic        v0, b0, acc, go, leave;
      logic [63:0] tx0;
      int          want_beats;
      start = st; stop = sp; usr_tx_ready = rdy;
      burst_len = 16'(bl);
      #1;
      v0  = usr_tx_valid;
      b0  = busy;
      tx0 = usr_tx;
      acc = v0 && rdy;
      go  = !b0 && st && !sp;
      leave = b0 && ((acc && (sp || stop_pend)) || (!v0 && sp));
      if (acc) begin
         check("word", usr_tx, exp_pat);
         exp_pat = exp_pat + PAT_INC;
         if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
         burst_beats++;
      end
      if (go) begin
         exp_cnt = 32'd0; burst_beats = 0; gap_cycles = 0;
      end
      if (v0 && !acc && sp) stop_pend = 1'b1;
      @(posedge clk_usr);
      #1;
      start = 1'b0; stop = 1'b0;
      if (v0 && !acc) begin
         check("hold_valid", {63'd0, usr_tx_valid}, 64'd1);
         check("hold_data", usr_tx, tx0);
      end
      if (go) check("start_valid", {63'd0, usr_tx_valid}, 64'd1);
      if (leave || (!b0 && !go)) begin
         check("idle_busy", {63'd0, busy}, 64'd0);
         check("idle_valid", {63'd0, usr_tx_valid}, 64'd0);
         stop_pend = 1'b0; burst_beats = 0; gap_cycles = 0;
      end else begin
         check("run_busy", {63'd0, busy}, 64'd1);
         if (v0 && acc && !usr_tx_valid) begin
            want_beats = (bl == 0) ? 1 : bl;
            check("burst_beats", 64'(burst_beats), 64'(want_beats));
            burst_beats = 0;
         end
         if (b0 && !v0 && usr_tx_valid) begin
            check("gap_len", 64'(gap_cycles), 64'(GAP_LEN));
            gap_cycles = 0;
         end
         if (busy && !usr_tx_valid) gap_cycles++;
      end
      check("word_cnt", {32'd0, word_cnt}, {32'd0, exp_cnt});
      @(negedge clk_usr);
   endtask

   // Called at a falling edge; asserts reset, checks it acts before any clock, returns at a falling edge.
   task automatic do_reset();
      rst = 1'b1; start = 1'b0; stop = 1'b0; usr_tx_ready = 1'b0;
      #1;
      check("rst_valid", {63'd0, usr_tx_valid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_tx", usr_tx, PAT_INIT);
      check("rst_cnt", {32'd0, word_cnt}, 64'd0);
      @(negedge clk_usr);
      @(negedge clk_usr);
      rst = 1'b0;
      exp_pat = PAT_INIT; exp_cnt = 32'd0; stop_pend = 1'b0;
      burst_beats = 0; gap_cycles = 0;
   endtask

   initial begin
      first_words[0] = 64'h0000_0002_0000_0001;
      first_words[1] = 64'h0000_0004_0000_0003;
      first_words[2] = 64'h0000_0006_0000_0005;
      first_words[3] = 64'h0000_0008_0000_0007;
      @(negedge clk_usr);
      do_reset();

      // Basic run: four words, eight idle cycles, second burst continues the sequence.
      bl = 4;
      cyc(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("first_words", usr_tx, first_words[i]);
         cyc(1'b0, 1'b0, 1'b1);
      end
      for (int i = 0; i < GAP_LEN; i++) begin
         check("gap_valid", {63'd0, usr_tx_valid}, 64'd0);
         check("gap_busy", {63'd0, busy}, 64'd1);
         cyc(1'b0, 1'b0, 1'b1);
      end
      check("burst2_valid", {63'd0, usr_tx_valid}, 64'd1);
      check("burst2_word", usr_tx, 64'h0000_000A_0000_0009);

      // Backpressure in the middle of a burst.
      cyc(1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
      check("bp_word", usr_tx, 64'h0000_000C_0000_000B);
      check("bp_cnt", {32'd0, word_cnt}, 64'd5);

      // Stop while the word is stalled; it still goes out, then the run ends.
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      check("stop_busy", {63'd0, busy}, 64'd0);
      check("stop_cnt", {32'd0, word_cnt}, 64'd6);
      cyc(1'b1, 1'b0, 1'b1);
      check("restart_cnt", {32'd0, word_cnt}, 64'd0);
      check("restart_word", usr_tx, 64'h0000_000E_0000_000D);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);

      // 64-bit wrap of the pattern.
      force dut.pat_q = 64'hFFFF_FFFE_FFFF_FFFF;
      #1;
      release dut.pat_q;
      exp_pat = 64'hFFFF_FFFE_FFFF_FFFF;
      check("force_tx", usr_tx, 64'hFFFF_FFFE_FFFF_FFFF);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      check("wrap_word", usr_tx, 64'h0000_0001_0000_0001);
      cyc(1'b0, 1'b1, 1'b1);

      // Start and stop together in IDLE: stop wins.
      cyc(1'b1, 1'b1, 1'b1);
      check("startstop_busy", {63'd0, busy}, 64'd0);

      // Zero burst length behaves as one word per burst.
      bl = 0;
      cyc(1'b1, 1'b0, 1'b1);
      check("bl0_valid", {63'd0, usr_tx_valid}, 64'd1);
      cyc(1'b0, 1'b0, 1'b1);
      check("bl0_gap", {63'd0, usr_tx_valid}, 64'd0);
      for (int i = 0; i < 2 * (GAP_LEN + 1); i++) cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 1'b1);

      // Reset in the middle of a burst.
      bl = 4;
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      check("pre_rst_valid", {63'd0, usr_tx_valid}, 64'd1);
      do_reset();
      cyc(1'b1, 1'b0, 1'b1);
      check("post_rst_word", usr_tx, PAT_INIT);
      cyc(1'b0, 1'b1, 1'b1);

`ifdef PATGEN_ERR_INJ_EN
      do_reset();
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      err_inj = 1'b1; usr_tx_ready = 1'b0;
      @(posedge clk_usr);
      #1;
      err_inj = 1'b0;
      check("inj_word3", usr_tx, 64'h0000_0006_0000_0004);
      usr_tx_ready = 1'b1;
      @(posedge clk_usr);
      #1;
      check("inj_word4", usr_tx, 64'h0000_0008_0000_0007);
      @(negedge clk_usr);
      do_reset();
`endif

      // Randomized traffic against the scoreboard.
      for (int i = 0; i < 3000; i++) begin
         logic st, sp, rdy;
         rdy = ($urandom_range(0, 9) < 7);
         st  = ($urandom_range(0, 19) == 0);
         sp  = ($urandom_range(0, 59) == 0);
         if (st && !busy) bl = int'($urandom_range(0, 6));
         cyc(st, sp, rdy);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_gen_64b.md
PATTERN_GEN_64B -- requirements
Module: pattern_gen_64b

Interface
REQ-001 The block SHALL have parameter GAP_LEN, default 8, giving the idle cycles between bursts (range 0..255).
REQ-002 The block SHALL have port clk_usr  input  1  user clock; all logic is rising-edge on clk_usr.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 The block SHALL have port start  input  1  single-cycle pulse that begins a run.
REQ-005 The block SHALL have port stop  input  1  single-cycle pulse that ends a run.
REQ-006 The block SHALL have port burst_len  input  16  words per burst, sampled at start and at each burst reload.
REQ-007 The block SHALL have port usr_tx  output  64  pattern word.
REQ-008 The block SHALL have port usr_tx_valid  output  1  usr_tx holds a word.
REQ-009 The block SHALL have port usr_tx_ready  input  1  the downstream stage accepts the word.
REQ-010 The block SHALL have port busy  output  1  the block is not in IDLE.
REQ-011 The block SHALL have port word_cnt  output  32  count of accepted words in the current run.

Function
REQ-012 Beat accepted = usr_tx_valid && usr_tx_ready in the same cycle.
REQ-013 Internal pattern register: 0x0000_0002_0000_0001 after reset; adds 0x0000_0002_0000_0002 per accepted beat; modulo 2^64, wraps silently.
REQ-014 The pattern register SHALL NOT reset on start or stop; the sequence continues across runs, so the downstream checker sees one unbroken sequence.
REQ-015 The state machine SHALL have three states: IDLE, BURST and GAP; usr_tx_valid = (state == BURST), registered.
REQ-016 IDLE: start=1 and stop=0 -> BURST next cycle (start in cycle N -> valid in N+1); load beat_left = burst_len, with 0 treated as 1; clear word_cnt.
REQ-017 BURST: on each accept, decrement beat_left; the accept with beat_left==1 -> GAP, or -> BURST with reload if GAP_LEN==0.
REQ-018 GAP: count GAP_LEN cycles, then -> BURST with beat_left reloaded from burst_len.
REQ-019 Once usr_tx_valid=1, usr_tx SHALL be held stable until accepted; valid SHALL NOT drop without an accept, except on rst.
REQ-020 stop in BURST: set stop_req; the pending word is held until accepted, then -> IDLE regardless of beat_left.
REQ-021 stop in GAP: -> IDLE next cycle.
REQ-022 stop and start in the same cycle in IDLE: stop wins, stay IDLE.
REQ-023 start while busy: ignored.
REQ-024 word_cnt: +1 per accept; saturates at 0xFFFF_FFFF; holds its value in IDLE.
REQ-025 busy = (state != IDLE), registered.

Reset
REQ-026 rst SHALL asynchronously force: state=IDLE, usr_tx_valid=0, usr_tx=0x0000_0002_0000_0001, busy=0, word_cnt=0, beat_left=0, gap counter=0, stop_req=0, inj_flag=0.
REQ-027 rst mid-burst SHALL drop valid immediately and restart the pattern at 0x0000_0002_0000_0001.

Configuration
REQ-028 Macro PATGEN_ERR_INJ_EN defined: add input port err_inj (1 bit).
REQ-029 With PATGEN_ERR_INJ_EN: an err_inj pulse sets inj_flag; while inj_flag=1, usr_tx = pattern XOR 1 (bit 0 inverted); inj_flag clears on the next accept; the internal pattern is unaffected.
REQ-030 Macro undefined: no err_inj port, no inj_flag; usr_tx = pattern always.

Verification
REQ-031 Reset, then start with burst_len=4, ready=1, GAP_LEN=8 -> valid from the cycle after start; words 0x0000_0002_0000_0001, ..._0004_0000_0003, ..._0006_0000_0005, ..._0008_0000_0007; then 8 idle cycles; next burst begins at 0x0000_000A_0000_0009.
REQ-032 Backpressure: ready low for 3 cycles mid-burst -> usr_tx and valid held unchanged; the pattern advances only on accept; word_cnt counts accepts only.
REQ-033 stop while valid=1 and ready=0, then ready=1 after 2 cycles -> that one word is accepted, then IDLE and busy=0; a second start resumes with the next pattern value, and word_cnt restarts from 0.
REQ-034 Force the pattern to 0xFFFF_FFFE_FFFF_FFFF and accept one beat -> next word 0x0000_0001_0000_0001 (wrap); start+stop in the same IDLE cycle -> stays IDLE; burst_len=0 -> one word per burst.
REQ-035 With PATGEN_ERR_INJ_EN: err_inj pulse before the 3rd word -> the 3rd word reads 0x0000_0006_0000_0004; the 4th word reads the correct 0x0000_0008_0000_0007.
REQ-036 Assert rst mid-burst -> valid=0 in the same cycle; after release and start, the first word is 0x0000_0002_0000_0001.
